// File: rtl/fifo_bank_4_pkg.sv
// fifo_bank_4_pkg: shared sizing defaults and helpers for the four-lane FIFO bank
package fifo_bank_4_pkg;
   localparam int LANES      = 4;
   localparam int DATA_W_DEF = 12;
   localparam int DEPTH_DEF  = 8;
   localparam int PTR_W_DEF  = 3;
   function automatic logic multi_hot(input logic [LANES-1:0] v);
      return |(v & (v - LANES'(1)));
   endfunction
endpackage

// File: rtl/fifo_bank_4_lane.sv
// fifo_lane: one circular FIFO lane with registered read port and sticky error flags
import fifo_bank_4_pkg::*;
module fifo_lane #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int PTR_W  = PTR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              illegal,
   input  logic              pop,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PTR_W:0]    afull_thr,
   input  logic [PTR_W:0]    aempty_thr,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              overflow,
   output logic              underflow
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic              wr, rd;
   assign full         = count == (PTR_W+1)'(DEPTH);
   assign empty        = count == '0;
   assign almost_full  = count >= afull_thr;
   assign almost_empty = count <= aempty_thr;
   assign rd = pop & ~empty;
   // a full lane still accepts a write when a read frees a slot on the same edge
   assign wr = push & ~illegal & (~full | rd);
   always_ff @(posedge clk)
      if (wr && !reset) mem[wr_ptr] <= data_in;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (rd) data_out <= mem[rd_ptr];
         count     <= count + (PTR_W+1)'(wr) - (PTR_W+1)'(rd);
         valid_out <= rd;
         overflow  <= overflow | (push & ~wr);
         underflow <= underflow | (pop & empty);
      end
   end
endmodule

// File: rtl/fifo_bank_4.sv
// fifo_bank_4: four independent FIFO lanes behind a one-hot push strobe
import fifo_bank_4_pkg::*;
module fifo_bank_4 #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int PTR_W  = PTR_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [3:0]              push,
   input  logic [DATA_W-1:0]       data_in,
   input  logic [3:0]              pop,
   input  logic [PTR_W:0]          afull_thr,
   input  logic [PTR_W:0]          aempty_thr,
   output logic [4*DATA_W-1:0]     data_out,
   output logic [3:0]              valid_out,
   output logic [3:0]              full,
   output logic [3:0]              empty,
   output logic [3:0]              almost_full,
   output logic [3:0]              almost_empty,
   output logic [3:0]              overflow,
   output logic [3:0]              underflow
);
   logic illegal;
   assign illegal = multi_hot(push);
   for (genvar i = 0; i < 4; i++) begin : g_lane
      fifo_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_lane (
         .clk(clk), .reset(reset), .push(push[i]), .illegal(illegal), .pop(pop[i]),
         .data_in(data_in), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
         .data_out(data_out[DATA_W*i +: DATA_W]), .valid_out(valid_out[i]),
         .full(full[i]), .empty(empty[i]), .almost_full(almost_full[i]),
         .almost_empty(almost_empty[i]), .overflow(overflow[i]), .underflow(underflow[i])
      );
   end
endmodule
